pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed-field MEM/WB-style stage registers.
- Carries an opaque payload of DATA_W bits with a valid/ready handshake on both sides.
- Has a 2-entry skid buffer, so upstream back-pressure is fully registered and the stage still sustains 1 transfer/cycle.
- Has a synchronous flush input for squashing in-flight instructions on redirect. Used between any two core stages (IF/ID ... MEM/WB) by concatenating the stage fields into the payload.

Parameters:
- DATA_W, 32: payload width in bits (≥1).
- RST_VAL, '0: value loaded into both payload registers on reset and on flush.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  synchronous squash of all held entries.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  stage can accept upstream payload.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  downstream payload valid.
- out_ready_i  input  1  downstream accepts payload.
- out_data_o  output  DATA_W  downstream payload.
- occ_o  output  2  current occupancy, 0..2.
- stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.
- bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0 and out_ready_i=1.

Behaviour:
- Interface: one clock, clk_i. Reset is asynchronous and active-high, rst_i: asserts immediately and is released synchronously to clk_i.
- Storage: main register (drives out_data_o), skid register, state ∈ {EMPTY(occ 0), ONE(occ 1), TWO(occ 2)}.
- Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Output decode:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != TWO) & !rst_i. Depends only on flops and reset; there is no combinational path from out_ready_i.
  - occ_o = state encoding.
- Transitions when flush_i=0:
  - EMPTY: in_fire → ONE, main<=in_data_i.
  - ONE:
    - in_fire & out_fire → ONE, main<=in_data_i.
    - in_fire only → TWO, skid<=in_data_i.
    - out_fire only → EMPTY.
    - neither → hold.
  - TWO (in_ready_o=0): out_fire → ONE, main<=skid. Otherwise hold.
- Flush (flush_i=1):
  - Highest priority over all handshakes.
  - Next state EMPTY; main and skid <= RST_VAL.
  - A coincident in_fire or out_fire is dropped: the downstream must ignore out_fire in a flush cycle, and the upstream entry is lost.
- Latency and ordering:
  - 1 cycle from in_fire to out_valid_o when EMPTY, or when ONE with a concurrent out_fire.
  - Throughput 1/cycle in steady state. Strict FIFO order.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold unchanged.
- in_data_i is sampled only on in_fire. Payload is never modified or reordered.
- Reset values:
  - state EMPTY; main = skid = RST_VAL.
  - out_valid_o=0, out_data_o=RST_VAL, occ_o=0, in_ready_o=0 while rst_i=1, counters 0.
  - in_ready_o=1 in the first cycle after release.
- Reset mid-operation: all held entries are discarded immediately, with no handshake completion.
- EMPTY with out_ready_i=1 and no input: nothing happens, no underflow.
- TWO with in_valid_i=1: input is not accepted, no overflow.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o and bubble_cnt_o are live registered counters, updated each cycle per their port definitions.
  - Both saturate at all-ones.
  - Cleared by rst_i only; flush_i does not clear them.
  - A flush cycle is counted per the pre-flush out_valid_o/out_ready_i values.
- Not defined: both ports are tied to 0 and no counter flops are built. The port list is identical in both builds.

Test Plan:
- Reset: rst_i=1 asynchronously mid-cycle with occ=2 → out_valid_o=0, occ_o=0, out_data_o=RST_VAL immediately. After release, in_ready_o=1.
- Streaming: out_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles → out_data_o shows 0x11,0x22,0x33 one cycle after each push, occ_o=1 throughout, no gaps.
- Skid/back-pressure:
  - Push 0xA, 0xB with out_ready_i=0 → occ_o=2, in_ready_o=0, out_data_o=0xA stable.
  - Raise out_ready_i → 0xA then 0xB delivered in order, in_ready_o=1 one cycle after the first out_fire.
- Simultaneous: in ONE holding 0x5, in_fire(0x6) with out_fire in the same cycle → next cycle out_data_o=0x6, occ_o=1.
- Flush: occ=2, flush_i=1 with in_valid_i=1 (0x77) → next cycle occ_o=0, out_valid_o=0, out_data_o=RST_VAL, and 0x77 is never delivered.
- Counters (PIPE_PERF_CNT_EN):
  - 5 cycles out_valid=1 & out_ready_i=0 → stall_cnt_o=5.
  - With CNT_W=3, 10 bubble cycles → bubble_cnt_o=7 (saturated).
  - Without the macro, both ports read 0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with a 2-entry skid buffer and flush.
// Define PIPE_PERF_CNT_EN to build the saturating stall/bubble counters.
module pipe_stage_hs #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              in_fire, out_fire;
    assign out_valid_o = state_q != EMPTY;
    assign in_ready_o  = (state_q != TWO) && !rst_i;
    assign occ_o       = state_q;
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
    // Flush wins over both handshakes; a coincident transfer is simply dropped.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    state_d = in_fire ? ONE : EMPTY;
                    main_d  = in_fire ? in_data_i : main_q;
                end
                ONE: begin
                    state_d = (in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE;
                    main_d  = (in_fire && out_fire) ? in_data_i : main_q;
                    skid_d  = (in_fire && !out_fire) ? in_data_i : skid_q;
                end
                TWO: begin
                    state_d = out_fire ? ONE : TWO;
                    main_d  = out_fire ? skid_q : main_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, bubble_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (!out_valid_o && out_ready_i && !(&bubble_q)) bubble_q <= bubble_q + 1'b1;
        end
    end
    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for pipe_stage_hs, directed cases then random traffic.
module tb_pipe_stage_hs;
    localparam int              DW    = 8;
    localparam int              CW    = 3;
    localparam logic [DW-1:0]   RV    = 8'hE5;
    localparam int              CMAX  = (1 << CW) - 1;
    logic          clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] idle_data = RV;
    bit            pushed_now = 0;
    int            stall_m = 0, bubble_m = 0;
    int            n_chk = 0, n_fail = 0;

    pipe_stage_hs #(.DATA_W(DW), .RST_VAL(RV), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occ_o(occ), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_exp(input int m);
`ifdef PIPE_PERF_CNT_EN
        return m;
`else
        return 0;
`endif
    endfunction

    // Drive one cycle of stimulus; the scoreboard learns of every accepted input here.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        pushed_now = v && in_ready && !f;
        if (pushed_now) exp_q.push_back(d);
    endtask

    task automatic clear_model();
        exp_q.delete();
        idle_data = RV;
        pushed_now = 0;
        stall_m = 0;
        bubble_m = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1;
        in_valid = 0; out_ready = 0; flush = 0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Monitor: compares DUT against the queue model in the middle of every cycle.
    always @(negedge clk) begin
        int held;
        if (!rst) begin
            held = exp_q.size() - int'(pushed_now);
            chk("occ", 32'(occ), 32'(held));
            chk("out_valid", 32'(out_valid), 32'(held > 0));
            chk("in_ready", 32'(in_ready), 32'(held < 2));
            chk("out_data", 32'(out_data), 32'(held > 0 ? exp_q[0] : idle_data));
            chk("stall_cnt", 32'(stall_cnt), 32'(cnt_exp(stall_m)));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(cnt_exp(bubble_m)));
            if (held > 0 && !out_ready && stall_m < CMAX) stall_m++;
            if (held == 0 && out_ready && bubble_m < CMAX) bubble_m++;
            if (flush) begin
                exp_q.delete();
                idle_data = RV;
            end else if (held > 0 && out_ready) begin
                idle_data = exp_q.pop_front();
            end
        end
    end

    initial begin
        #2;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // async reset with two entries held
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("pre_reset_occ", 32'(occ), 32'd2);
        @(posedge clk);
        #3;
        rst = 1;
        in_valid = 0; out_ready = 0;
        clear_model();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_data", 32'(out_data), 32'(RV));
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("release_ready", 32'(in_ready), 32'd1);

        // streaming
        cyc(1, 8'h11, 1, 0);
        cyc(1, 8'h22, 1, 0);
        @(negedge clk);
        chk("stream_data0", 32'(out_data), 32'h11);
        cyc(1, 8'h33, 1, 0);
        @(negedge clk);
        chk("stream_data1", 32'(out_data), 32'h22);
        cyc(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("stream_data2", 32'(out_data), 32'h33);
        chk("stream_occ", 32'(occ), 32'd1);
        cyc(0, 8'h00, 1, 0);

        // skid / back-pressure
        do_reset();
        cyc(1, 8'h0A, 0, 0);
        cyc(1, 8'h0B, 0, 0);
        cyc(1, 8'h0C, 0, 0);
        @(negedge clk);
        chk("skid_occ", 32'(occ), 32'd2);
        chk("skid_ready", 32'(in_ready), 32'd0);
        chk("skid_data", 32'(out_data), 32'h0A);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("skid_ready_back", 32'(in_ready), 32'd1);
        chk("skid_second", 32'(out_data), 32'h0B);
        cyc(0, 8'h00, 1, 0);

        // simultaneous in/out fire
        do_reset();
        cyc(1, 8'h05, 0, 0);
        cyc(1, 8'h06, 1, 0);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("simul_data", 32'(out_data), 32'h06);
        chk("simul_occ", 32'(occ), 32'd1);

        // flush from full with a coincident input
        cyc(1, 8'h07, 0, 0);
        cyc(1, 8'h77, 1, 1);
        cyc(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("flush_occ", 32'(occ), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'(RV));
        cyc(0, 8'h00, 1, 0);

        // stall counter: five stall cycles
        do_reset();
        cyc(1, 8'h42, 0, 0);
        repeat (6) cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("stall5", 32'(stall_cnt), 32'(cnt_exp(5)));

        // bubble counter saturation
        do_reset();
        repeat (11) cyc(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("bubble_sat", 32'(bubble_cnt), 32'(cnt_exp(7)));

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 10) < 7, ($urandom % 32) == 0);
        repeat (4) cyc(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("drain_occ", 32'(occ), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
